// File: rtl/bus_memory_controller_if.sv
// rtl/bus_memory_controller_if.sv - CPU address/control and transmit stream signals of the memory controller
interface bus_memory_controller_if;
    logic [11:0] addressBus;
    logic        write;
    logic        sync;
    logic [7:0]  txData;
    logic        txValid;
    logic        txReady;

    modport master (
        output addressBus, write, sync, txReady,
        input  txData, txValid
    );

    modport slave (
        input  addressBus, write, sync, txReady,
        output txData, txValid
    );
endinterface

// File: rtl/bus_memory_controller.sv
// rtl/bus_memory_controller.sv - RAM plus I/O page (tx FIFO, timer, fetch counter) slave on the CPU bus
module bus_memory_controller #(
    parameter int          RAM_DEPTH  = 3840,
    parameter logic [11:0] IO_BASE    = 12'hF00,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic                          clock,
    input  logic                          resetN,
    inout  wire  [7:0]                    dataBus,
    bus_memory_controller_if.slave        bus
);
    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [12:0] RAM_TOP = 13'(RAM_DEPTH);
    localparam logic [AW:0] FULL_CT = (AW+1)'(FIFO_DEPTH);

    logic [7:0]  ram [RAM_DEPTH];
    logic [7:0]  fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic        overflow;
    logic [15:0] timer, fetch_count;
    logic [7:0]  timer_hi_snap;
    logic [7:0]  rd_data;

    logic        ram_hit, io_hit;
    logic [11:0] io_off;
    logic        empty, full, push, pop, push_ok, status_wr;

    assign ram_hit   = {1'b0, bus.addressBus} < RAM_TOP;
    assign io_off    = bus.addressBus - IO_BASE;
    assign io_hit    = (bus.addressBus >= IO_BASE) && (io_off < 12'd6);
    assign empty     = (count == '0);
    assign full      = (count == FULL_CT);
    assign push      = bus.write && io_hit && (io_off == 12'd0);
    assign status_wr = bus.write && io_hit && (io_off == 12'd1);
    assign pop       = !empty && bus.txReady;
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign push_ok   = push && (!full || pop);

    assign bus.txValid = !empty;
    assign bus.txData  = empty ? 8'h00 : fifo_mem[rptr];

    // Combinational read mux; unmapped addresses float high as 0xFF.
    always_comb begin
        rd_data = 8'hFF;
        if (ram_hit) begin
            rd_data = ram[bus.addressBus];
        end else if (io_hit) begin
            case (io_off[2:0])
                3'd0:    rd_data = 8'h00;
                3'd1:    rd_data = {5'b0, overflow, full, empty};
                3'd2:    rd_data = timer[7:0];
                3'd3:    rd_data = timer_hi_snap;
                3'd4:    rd_data = fetch_count[7:0];
                3'd5:    rd_data = fetch_count[15:8];
                default: rd_data = 8'hFF;
            endcase
        end
    end

    assign dataBus = (resetN && !bus.write) ? rd_data : 8'hzz;

    // RAM and FIFO storage carry no reset; validity comes from the write path and FIFO count.
    always_ff @(posedge clock) begin
        if (bus.write && ram_hit)
            ram[bus.addressBus] <= dataBus;
        if (push_ok)
            fifo_mem[wptr] <= dataBus;
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (status_wr)
                overflow <= 1'b0;
            else if (push && full && !pop)
                overflow <= 1'b1;
        end
    end

    // Free-running timer, sync-driven fetch counter, and the high-byte snapshot taken on a TIMER_LO read.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            timer         <= '0;
            fetch_count   <= '0;
            timer_hi_snap <= '0;
        end else begin
            timer <= timer + 16'd1;
            if (bus.sync)
                fetch_count <= fetch_count + 16'd1;
            if (!bus.write && io_hit && (io_off == 12'd2))
                timer_hi_snap <= timer[15:8];
        end
    end
endmodule

// File: tb/tb_bus_memory_controller.sv
// tb/tb_bus_memory_controller.sv - directed self-checking bench for bus_memory_controller
module tb_bus_memory_controller;
    logic       clock = 1'b0;
    logic       resetN = 1'b0;
    logic       drv = 1'b0;
    logic [7:0] wdata = 8'h00;
    wire  [7:0] dataBus;
    int         checks = 0;
    int         errors = 0;

    bus_memory_controller_if bus();

    assign dataBus = drv ? wdata : 8'hzz;

    bus_memory_controller dut (
        .clock   (clock),
        .resetN  (resetN),
        .dataBus (dataBus),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_write(input logic [11:0] a, input logic [7:0] d);
        bus.addressBus = a;
        wdata = d;
        drv = 1'b1;
        bus.write = 1'b1;
        tick();
        bus.write = 1'b0;
        drv = 1'b0;
    endtask

    task automatic read_chk(input logic [11:0] a, input logic [7:0] exp, input string tag);
        bus.addressBus = a;
        #1;
        check(tag, dataBus, exp);
    endtask

    initial begin
        bus.addressBus = 12'hF80;
        bus.write = 1'b0;
        bus.sync = 1'b0;
        bus.txReady = 1'b0;

        // Reset: DUT must release the bus, so the bench's value reads back unaltered.
        drv = 1'b1;
        wdata = 8'h3C;
        #12;
        check("z_in_reset", dataBus, 8'h3C);
        check("txvalid_reset", {7'b0, bus.txValid}, 8'h00);
        check("txdata_reset", bus.txData, 8'h00);
        drv = 1'b0;
        @(posedge clock);
        #1;
        resetN = 1'b1;

        read_chk(12'hF01, 8'h01, "status_reset");
        read_chk(12'hF02, 8'h00, "timer_lo_reset");
        read_chk(12'hF03, 8'h00, "timer_hi_reset");
        read_chk(12'hF04, 8'h00, "fetch_lo_reset");
        read_chk(12'hF05, 8'h00, "fetch_hi_reset");

        // Timer snapshot: 0x1FF edges after release.
        bus.addressBus = 12'hF80;
        repeat (16'h01FF) tick();
        read_chk(12'hF02, 8'hFF, "timer_lo_1ff");
        tick();
        read_chk(12'hF03, 8'h01, "timer_hi_snap");
        bus.addressBus = 12'hF80;
        repeat (3) tick();
        read_chk(12'hF03, 8'h01, "timer_hi_not_live");

        // RAM and unmapped space.
        do_write(12'h123, 8'hA5);
        read_chk(12'h123, 8'hA5, "ram_rd");
        do_write(12'h000, 8'h5A);
        read_chk(12'h000, 8'h5A, "ram_rd_0");
        read_chk(12'h123, 8'hA5, "ram_rd_keep");
        read_chk(12'hF80, 8'hFF, "unmapped_rd");
        do_write(12'hF80, 8'h55);
        read_chk(12'hF01, 8'h01, "unmapped_wr_status");

        // FIFO fill with consumer stalled.
        for (int i = 1; i <= 8; i++) do_write(12'hF00, 8'(i));
        read_chk(12'hF01, 8'h02, "status_full");
        check("txdata_head", bus.txData, 8'h01);
        read_chk(12'hF00, 8'h00, "txdata_reg_rd");
        do_write(12'hF00, 8'h09);
        read_chk(12'hF01, 8'h06, "status_overflow");

        // Drain.
        bus.txReady = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            #1;
            check($sformatf("drain_%0d", i), bus.txData, 8'(i));
            tick();
        end
        bus.txReady = 1'b0;
        check("txvalid_drained", {7'b0, bus.txValid}, 8'h00);
        read_chk(12'hF01, 8'h05, "status_empty_ovf");
        do_write(12'hF01, 8'h00);
        read_chk(12'hF01, 8'h01, "status_cleared");

        // Full FIFO with simultaneous push and pop.
        for (int i = 0; i < 8; i++) do_write(12'hF00, 8'(8'h10 + i));
        read_chk(12'hF01, 8'h02, "status_full2");
        bus.txReady = 1'b1;
        do_write(12'hF00, 8'hEE);
        bus.txReady = 1'b0;
        read_chk(12'hF01, 8'h02, "status_full_no_ovf");
        bus.txReady = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            #1;
            check($sformatf("drain2_%0d", i), bus.txData, (i == 8) ? 8'hEE : 8'(8'h10 + i));
            tick();
        end
        bus.txReady = 1'b0;
        read_chk(12'hF01, 8'h01, "status_empty2");

        // Push into empty FIFO: no bypass, valid next cycle.
        do_write(12'hF00, 8'h77);
        check("push_valid", {7'b0, bus.txValid}, 8'h01);
        check("push_data", bus.txData, 8'h77);

        // Fetch counter.
        bus.addressBus = 12'hF80;
        bus.sync = 1'b1;
        repeat (300) tick();
        bus.sync = 1'b0;
        read_chk(12'hF05, 8'h01, "fetch_hi_300");
        read_chk(12'hF04, 8'h2C, "fetch_lo_300");

        // Asynchronous reset mid-count.
        bus.sync = 1'b1;
        repeat (10) tick();
        #2;
        resetN = 1'b0;
        #1;
        check("txvalid_async_rst", {7'b0, bus.txValid}, 8'h00);
        bus.sync = 1'b0;
        @(posedge clock);
        #1;
        resetN = 1'b1;
        read_chk(12'hF04, 8'h00, "fetch_lo_after_rst");
        read_chk(12'hF05, 8'h00, "fetch_hi_after_rst");
        read_chk(12'hF01, 8'h01, "status_after_rst");
        read_chk(12'hF02, 8'h00, "timer_after_rst");
        tick();
        read_chk(12'hF02, 8'h01, "timer_first_edge");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bus_memory_controller.md
# bus_memory_controller

Memory and I/O slave that sits directly downstream of the 8-bit CPU on its 12-bit address / 8-bit bidirectional data bus. It serves all CPU reads and writes: a RAM region, plus a small memory-mapped I/O page. The I/O page holds a transmit FIFO with a valid/ready output stream, a free-running cycle timer, and an opcode-fetch counter driven by `sync`.

## Interface
- `RAM_DEPTH`, default 3840: RAM bytes, mapped at 0x000 upward; must be ≤ `IO_BASE`.
- `IO_BASE`, default 12'hF00: base address of the I/O page.
- `FIFO_DEPTH`, default 8: transmit FIFO entries (power of two, ≥2).
- `clock  in  1`: single clock, all state on rising edge.
- `resetN  in  1`: asynchronous, active-low reset.
- `addressBus  in  12`: CPU address.
- `dataBus  inout  8`: CPU data; driven by this block on reads, high-Z otherwise.
- `write  in  1`: 1 = CPU write cycle, 0 = read cycle.
- `sync  in  1`: high during an opcode-fetch cycle.
- `txData  out  8`: FIFO head byte.
- `txValid  out  1`: FIFO non-empty.
- `txReady  in  1`: downstream consumer accepts head.

## Operation
- Address decode:
  - addr < `RAM_DEPTH` is RAM.
  - `IO_BASE`..`IO_BASE`+5 are registers.
  - Every other address is unmapped: reads return 0xFF, writes are ignored.
- Reads are combinational from `addressBus`: `dataBus` is driven whenever `resetN`=1 and `write`=0. It is high-Z when `write`=1 or `resetN`=0.
- Writes commit at the rising edge when `write`=1, using the `dataBus` value at that edge.
  - Each cycle with `write`=1 is a separate access. Holding `write` for N cycles at TXDATA pushes N times.
- RAM is not cleared by `resetN`; contents are undefined until written.
- I/O registers (offset from `IO_BASE`):
  - +0 TXDATA:
    - Write pushes a byte into the FIFO.
    - If the FIFO is full, the push is dropped and `overflow` is set (sticky).
    - Read returns 0x00.
  - +1 STATUS:
    - Read returns {5'b0, overflow, full, empty}.
    - Any write clears `overflow`.
  - +2 TIMER_LO:
    - Read returns timer[7:0].
    - At the rising edge ending that read cycle, timer[15:8] is latched into `timerHiSnap`.
  - +3 TIMER_HI: read returns `timerHiSnap`.
  - +4 FETCH_LO / +5 FETCH_HI: fetch counter bits [7:0] / [15:8], read directly with no snapshot.
  - Writes to +2..+5 are ignored.
- Timer: 16-bit; increments every clock; wraps 0xFFFF→0x0000.
- Fetch counter: 16-bit; increments at each rising edge with `sync`=1; wraps.
- FIFO:
  - Pop occurs at the rising edge when `txValid`=1 and `txReady`=1.
  - `txData` = head entry; 0x00 when empty.
  - Push and pop in the same cycle:
    - When full, the push is accepted, no overflow is flagged, and the occupancy stays at full.
    - When empty, only the push takes effect; there is no bypass, so `txValid` rises the next cycle.
- Reset values: `txValid`=0, `txData`=0x00, FIFO empty, `overflow`=0, timer=0, fetch counter=0, `timerHiSnap`=0, `dataBus` high-Z.
- Reset asserted mid-operation clears all of the above immediately (asynchronously). The next valid access is in the first cycle after `resetN` is released.

## Timing
- Read latency is 0 cycles. Data is valid within the same cycle `addressBus` changes, before the CPU's mid-cycle sample.
- Write latency is 1 edge. Written RAM data is readable from the next cycle.
- Push to TXDATA at edge k gives `txValid`=1 after edge k (when previously empty). `txData` equals the byte after the same edge.
- STATUS reflects FIFO state after the most recent edge. `full` and `overflow` update at the same edge as the push that causes them.
- Timer counts edges since reset release: the first edge after release makes it 1.

## Test plan
- Reset → `txValid`=0, STATUS reads 0x01, TIMER_LO/HI/FETCH read 0x00, `dataBus` Z while `resetN`=0.
- RAM: write 0xA5 to 0x123, then read 0x123 → 0xA5. Read 0xF80 → 0xFF. Write 0x55 to 0xF80 leaves STATUS unchanged.
- FIFO with `txReady`=0:
  - Push 0x01..0x08 → STATUS 0x02 (full).
  - Push 0x09 → STATUS 0x06 (full, overflow).
  - Set `txReady`=1 → `txData` 0x01..0x08 on successive cycles; STATUS ends 0x05 (empty, overflow).
  - Write STATUS → 0x01.
- Full FIFO, push 0xEE with `txReady`=1 in the same cycle → no overflow, occupancy stays 8, 0xEE is delivered last.
- Timer snapshot:
  - Run 0x01FF edges, then read TIMER_LO → 0xFF.
  - After further cycles, TIMER_HI → 0x01 (snapshot, not live).
- Fetch counter: assert `sync` on 300 edges → FETCH_HI=0x01, FETCH_LO=0x2C. Assert `resetN` low mid-count → both read 0x00 after release.
